// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: grants one writeback source per cycle onto the register-file write port and keeps a pending-write scoreboard.
// Optional round-robin arbitration is enabled with WB_ROUND_ROBIN_EN.  Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int AW      = 5,
   parameter int DW      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC-1:0]    src_req,
   input  logic [AW*NUM_SRC-1:0] src_addr,
   input  logic [DW*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]    src_gnt,
   input  logic                  rf_hold,
   input  logic                  alloc_valid,
   input  logic [AW-1:0]         alloc_addr,
   output logic                  rf_write,
   output logic [AW-1:0]         rf_addr,
   output logic [DW-1:0]         rf_data,
   output logic [31:0]           busy_vec
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [AW-1:0]      w_addr [NUM_SRC];
   logic [DW-1:0]      w_data [NUM_SRC];
   logic [NUM_SRC-1:0] w_gnt;
   logic [PW-1:0]      w_sel;
   logic               w_found;
   logic               w_xfer;
   logic [AW-1:0]      w_sel_addr;
   logic [DW-1:0]      w_sel_data;
   logic [31:0]        w_busy_nxt;

   logic               r_write;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_data;
   logic [31:0]        r_busy;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign w_addr[gi] = src_addr[AW*gi +: AW];
      assign w_data[gi] = src_data[DW*gi +: DW];
   end

`ifdef WB_ROUND_ROBIN_EN
   logic [PW-1:0] r_ptr;
   logic [PW:0]   w_sum;

   // Search order starts just after the last granted source and wraps.
   always_comb begin
      w_gnt   = '0;
      w_sel   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(NUM_SRC)) begin
            w_sum = w_sum - (PW+1)'(NUM_SRC);
         end
         if (!w_found && src_req[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_sum[PW-1:0];
         end
      end
      if (reset || rf_hold) begin
         w_found = 1'b0;
      end
      if (w_found) begin
         w_gnt[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= PW'(NUM_SRC - 1);
      end else if (w_xfer) begin
         r_ptr <= w_sel;
      end
   end
`else
   // Descending scan so the lowest requesting index is the final winner.
   always_comb begin
      w_gnt   = '0;
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_req[i]) begin
            w_found = 1'b1;
            w_sel   = PW'(i);
         end
      end
      if (reset || rf_hold) begin
         w_found = 1'b0;
      end
      if (w_found) begin
         w_gnt[w_sel] = 1'b1;
      end
   end
`endif

   assign w_xfer     = w_found;
   assign w_sel_addr = w_addr[w_sel];
   assign w_sel_data = w_data[w_sel];

   // Alloc is applied after the clear so a new producer supersedes the old one.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_xfer && (w_sel_addr != '0)) begin
         w_busy_nxt[w_sel_addr] = 1'b0;
      end
      if (alloc_valid && (alloc_addr != '0)) begin
         w_busy_nxt[alloc_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= '0;
      end else begin
         r_write <= w_xfer && (w_sel_addr != '0);
         r_busy  <= w_busy_nxt;
         if (w_xfer) begin
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
         end
      end
   end

   assign src_gnt  = w_gnt;
   assign rf_write = r_write;
   assign rf_addr  = r_addr;
   assign rf_data  = r_data;
   assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk;
   logic            reset;
   logic [N-1:0]    src_req;
   logic [AW*N-1:0] src_addr;
   logic [DW*N-1:0] src_data;
   logic [N-1:0]    src_gnt;
   logic            rf_hold;
   logic            alloc_valid;
   logic [AW-1:0]   alloc_addr;
   logic            rf_write;
   logic [AW-1:0]   rf_addr;
   logic [DW-1:0]   rf_data;
   logic [31:0]     busy_vec;

   regfile_wb_arbiter #(.NUM_SRC(N), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .src_req     (src_req),
      .src_addr    (src_addr),
      .src_data    (src_data),
      .src_gnt     (src_gnt),
      .rf_hold     (rf_hold),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .rf_write    (rf_write),
      .rf_addr     (rf_addr),
      .rf_data     (rf_data),
      .busy_vec    (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus state
   logic [N-1:0]  req;
   logic [AW-1:0] a_addr [N];
   logic [DW-1:0] a_data [N];
   logic [N-1:0]  obs_gnt;
   int            last_g;

   // reference model state
   logic          m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [31:0]   m_busy;
   int            m_ptr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_write = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_busy  = '0;
      m_ptr   = N - 1;
   endtask

   function automatic int pick(input logic [N-1:0] r, input logic h);
      if (h) return -1;
`ifdef WB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         int j = (m_ptr + k) % N;
         if (r[j]) return j;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (r[i]) return i;
      end
`endif
      return -1;
   endfunction

   // One cycle: drive at the falling edge, check the grant, then check registered outputs after the rising edge.
   task automatic step(input logic h, input logic av, input logic [AW-1:0] aa);
      logic [N-1:0] eg;
      @(negedge clk);
      src_req     = req;
      rf_hold     = h;
      alloc_valid = av;
      alloc_addr  = aa;
      for (int i = 0; i < N; i++) begin
         src_addr[AW*i +: AW] = a_addr[i];
         src_data[DW*i +: DW] = a_data[i];
      end
      #1;
      last_g  = pick(req, h);
      eg      = (last_g >= 0) ? (N'(1) << last_g) : '0;
      obs_gnt = src_gnt;
      chk("gnt", 64'(src_gnt), 64'(eg));
      if (last_g >= 0) begin
         m_write = (a_addr[last_g] != 0);
         m_addr  = a_addr[last_g];
         m_data  = a_data[last_g];
         if (a_addr[last_g] != 0) m_busy[a_addr[last_g]] = 1'b0;
         m_ptr = last_g;
      end else begin
         m_write = 1'b0;
      end
      if (av && aa != 0) m_busy[aa] = 1'b1;
      @(posedge clk);
      #1;
      chk("rf_write", 64'(rf_write), 64'(m_write));
      chk("rf_addr",  64'(rf_addr),  64'(m_addr));
      chk("rf_data",  64'(rf_data),  64'(m_data));
      chk("busy_vec", 64'(busy_vec), 64'(m_busy));
   endtask

   logic [31:0]  saved_busy;
   logic [N-1:0] pending;

   initial begin
      reset       = 1'b1;
      src_req     = '0;
      src_addr    = '0;
      src_data    = '0;
      rf_hold     = 1'b0;
      alloc_valid = 1'b0;
      alloc_addr  = '0;
      req         = '0;
      for (int i = 0; i < N; i++) begin
         a_addr[i] = '0;
         a_data[i] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_write", 64'(rf_write), 64'(0));
      chk("rst_addr",  64'(rf_addr),  64'(0));
      chk("rst_data",  64'(rf_data),  64'(0));
      chk("rst_busy",  64'(busy_vec), 64'(0));
      chk("rst_gnt",   64'(src_gnt),  64'(0));
      #2 reset = 1'b0;

      // all sources requesting continuously
      req = 3'b111;
      for (int i = 0; i < N; i++) begin
         a_addr[i] = AW'(10 + i);
         a_data[i] = 32'hA000_0000 + DW'(i);
      end
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 1'b0, '0);
`ifdef WB_ROUND_ROBIN_EN
         chk("all_order", 64'(obs_gnt), 64'(N'(1) << (c % N)));
`else
         chk("all_order", 64'(obs_gnt), 64'(3'b001));
`endif
      end

      // single source 1
      req       = 3'b010;
      a_addr[1] = 5'd5;
      a_data[1] = 32'hDEAD_BEEF;
      step(1'b0, 1'b0, '0);
      chk("s1_gnt",   64'(obs_gnt),  64'(3'b010));
      chk("s1_write", 64'(rf_write), 64'(1));
      chk("s1_addr",  64'(rf_addr),  64'(5));
      chk("s1_data",  64'(rf_data),  64'(32'hDEAD_BEEF));
      req = '0;
      step(1'b0, 1'b0, '0);
      chk("s1_after", 64'(rf_write), 64'(0));

      // hold for three cycles, pointer must not move
      req = 3'b111;
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 1'b0, '0);
         chk("hold_gnt", 64'(obs_gnt), 64'(0));
      end
      step(1'b0, 1'b0, '0);
`ifdef WB_ROUND_ROBIN_EN
      chk("hold_rel", 64'(obs_gnt), 64'(3'b100));
`else
      chk("hold_rel", 64'(obs_gnt), 64'(3'b001));
`endif
      req = '0;

      // alloc 7, then source 2 writes 7 two cycles later
      step(1'b0, 1'b1, 5'd7);
      chk("alloc7_set", 64'(busy_vec[7]), 64'(1));
      step(1'b0, 1'b0, '0);
      req       = 3'b100;
      a_addr[2] = 5'd7;
      a_data[2] = 32'h0000_0777;
      step(1'b0, 1'b0, '0);
      chk("w7_write", 64'(rf_write),    64'(1));
      chk("w7_addr",  64'(rf_addr),     64'(7));
      chk("w7_clear", 64'(busy_vec[7]), 64'(0));
      req = '0;

      // alloc 9 then alloc and write 9 in the same cycle
      step(1'b0, 1'b1, 5'd9);
      req       = 3'b001;
      a_addr[0] = 5'd9;
      a_data[0] = 32'h0000_0999;
      step(1'b0, 1'b1, 5'd9);
      chk("set_wins", 64'(busy_vec[9]), 64'(1));

      // address 0 write and alloc
      saved_busy = busy_vec;
      a_addr[0]  = 5'd0;
      step(1'b0, 1'b1, 5'd0);
      chk("r0_gnt",   64'(obs_gnt),  64'(3'b001));
      chk("r0_write", 64'(rf_write), 64'(0));
      chk("r0_busy",  64'(busy_vec), 64'(saved_busy));

      // mid-stream reset with rf_write=1 and busy_vec=6
      a_addr[0] = 5'd9;
      step(1'b0, 1'b0, '0);
      req = '0;
      step(1'b0, 1'b1, 5'd1);
      req       = 3'b001;
      a_addr[0] = 5'd3;
      step(1'b0, 1'b1, 5'd2);
      chk("pre_rst_busy",  64'(busy_vec), 64'(32'h0000_0006));
      chk("pre_rst_write", 64'(rf_write), 64'(1));
      req = 3'b111;
      for (int i = 0; i < N; i++) src_req = req;
      reset = 1'b1;
      #1;
      chk("mid_rst_write", 64'(rf_write), 64'(0));
      chk("mid_rst_busy",  64'(busy_vec), 64'(0));
      chk("mid_rst_gnt",   64'(src_gnt),  64'(0));
      #2 reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, '0);
      chk("post_rst_gnt", 64'(obs_gnt), 64'(3'b001));
      req = '0;

      // randomized traffic with request holding until granted
      pending = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
               pending[i] = 1'b1;
               a_addr[i]  = AW'($urandom_range(0, 31));
               a_data[i]  = $urandom;
            end
         end
         req = pending;
         step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
              AW'($urandom_range(0, 31)));
         if (last_g >= 0) pending[last_g] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
